midi_rx_sequencer: RTL and testbench
====================================

# midi_rx_sequencer

Receive-side controller for the serial UART in the MIDI example. It pops bytes from the UART receive buffer with correctly spaced single-cycle read strobes and parses them as a MIDI byte stream, including running status, real-time interleaving and SysEx skipping. It presents complete channel-voice messages to the synth voice logic over a valid/ready handshake. It sits between the UART receive port and the note/CC dispatch logic.

## Interface
- `OMNI`, default 1: 1 accepts all channels; 0 accepts only `LISTEN_CHANNEL`.
- `LISTEN_CHANNEL`, default 0: MIDI channel (0-15) accepted when `OMNI`=0.
- `clk`  in  1  system clock; the only clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `uart_valid`  in  1  UART receive buffer holds an unread byte.
- `uart_data`  in  8  UART receive byte; valid while `uart_valid`=1.
- `uart_re`  out  1  read strobe to UART; one cycle wide per byte.
- `msg_valid`  out  1  message fields valid.
- `msg_ready`  in  1  consumer accepts the message.
- `msg_type`  out  3  status[6:4]: 0 note-off, 1 note-on, 2 poly AT, 3 CC, 4 program, 5 channel AT, 6 pitch bend.
- `msg_channel`  out  4  status[3:0].
- `msg_data1`  out  7  first data byte.
- `msg_data2`  out  7  second data byte; 0 for single-data-byte types.

## Operation
- FSM states: WAIT, POP, PARSE, EMIT.
- WAIT: if `uart_valid`=1, latch `uart_data` into `byte_q` and go to POP.
- POP: `uart_re`=1 (Moore output). Always go to PARSE. The UART drops `uart_valid` at this edge, so no second read can occur.
- PARSE: classify `byte_q` and update parser registers `rs` (running status, with `rs_valid` flag), `idx` (0/1 data bytes held) and `d1`. Go to EMIT if a message completed and passed the channel filter, otherwise go to WAIT.
  - 0xF8-0xFF (real-time): ignored. `rs`, `rs_valid`, `idx` and `d1` are unchanged.
  - 0xF0-0xF7 (system common/SysEx): `rs_valid`←0, `idx`←0. Data bytes that follow are discarded until the next status byte 0x80-0xEF.
  - 0x80-0xEF: `rs`←byte, `rs_valid`←1, `idx`←0. A partial message is discarded.
  - Data byte (bit7=0) with `rs_valid`=0: discarded.
  - Data byte with `rs_valid`=1, type 4 or 5: completes the message with data1=byte, data2=0. `idx` stays 0.
  - Data byte, other types, `idx`=0: `d1`←byte, `idx`←1.
  - Data byte, other types, `idx`=1: completes the message with data1=`d1`, data2=byte. `idx`←0.
- Note-on with data2=0 is emitted as `msg_type`=0 (note-off), data2=0.
- Channel filter: when `OMNI`=0 and `rs[3:0]`≠`LISTEN_CHANNEL`, a completed message is dropped. Running status is still retained.
- Output fields are registered in PARSE on completion and held stable while `msg_valid`=1.
- EMIT: `msg_valid`=1. On `msg_ready`=1, go to WAIT.
  - No UART bytes are read while in EMIT.
  - Overrun while stalled is a UART-level loss. This block does not detect it.

## Timing
- Reset (async assert): state WAIT; `uart_re`=0, `msg_valid`=0, all `msg_*` fields 0; `rs_valid`=0, `idx`=0, `d1`=0, `byte_q`=0.
- Reset deassertion is used synchronously by the FSM (standard async-assert/sync-release at top level).
- Byte throughput: at most 1 byte per 3 cycles (WAIT→POP→PARSE). At 31250 baud this leaves ample margin.
- Latency: `uart_valid` first high in cycle t → `uart_re` in t+1 → PARSE in t+2 → `msg_valid` in t+3 (final data byte only).
- `msg_valid` and `msg_ready` both high in cycle c: accepted at the end of c. `msg_valid`=0 in c+1. The earliest next `uart_re` is c+2.
- `msg_ready` high while `msg_valid`=0: no effect.
- Reset mid-message: partial message and running status are discarded. No `msg_valid` is emitted for pre-reset bytes.

## Structure
- Package `midi_pkg`:
  - `midi_type_t` (3-bit enum, codes as above).
  - Constants `MIDI_RT_MIN`=8'hF8, `MIDI_SYS_MIN`=8'hF0.
  - `midi_nbytes(type)` function returning 1 or 2.
  - FSM state typedef.
- One combinational sub-module `midi_byte_classify`. It takes the byte and returns is_status, is_realtime, is_system and nbytes. It is reused by the planned MIDI-thru block.

## Test plan
- 0x90,0x3C,0x64 → one message: type 1, ch 0, d1 0x3C, d2 0x64, `msg_valid` 3 cycles after the last byte's `uart_valid`. Each `uart_re` pulse is exactly 1 cycle.
- Running status 0x91,0x40,0x50,0x41,0x00 → note-on ch1 (0x40,0x50), then note-off ch1 (0x41,0x00).
- 0xB0,0x07,0xF8,0x7F → CC ch0 d1 0x07 d2 0x7F; the real-time byte is ignored. Also 0xC5,0x0A → type 4 ch5 d1 0x0A d2 0.
- 0xF0,0x01,0x02,0xF7,0x10 then 0x80,0x30,0x00 → the first sequence emits nothing; the second emits note-off 0x30.
- `OMNI`=0, `LISTEN_CHANNEL`=2: 0x93,0x10,0x20 dropped; 0x92,0x10,0x20 emitted. With `msg_ready` held low for 50 cycles, `uart_re` stays 0 and fields stay stable. `resetn` pulsed between 0x90 and 0x3C → no message.

Source files
------------

// File: rtl/midi_pkg.sv
// Shared MIDI definitions: message type codes, status byte ranges and the
// receive sequencer state encoding.
package midi_pkg;

  typedef enum logic [2:0] {
    MIDI_NOTE_OFF   = 3'd0,
    MIDI_NOTE_ON    = 3'd1,
    MIDI_POLY_AT    = 3'd2,
    MIDI_CC         = 3'd3,
    MIDI_PROGRAM    = 3'd4,
    MIDI_CHAN_AT    = 3'd5,
    MIDI_PITCH_BEND = 3'd6
  } midi_type_t;

  localparam logic [7:0] MIDI_RT_MIN  = 8'hF8;
  localparam logic [7:0] MIDI_SYS_MIN = 8'hF0;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_POP   = 2'd1,
    ST_PARSE = 2'd2,
    ST_EMIT  = 2'd3
  } rx_state_t;

  // Program change and channel aftertouch carry one data byte, all others two.
  function automatic logic [1:0] midi_nbytes(input midi_type_t msg_type);
    return (msg_type == MIDI_PROGRAM || msg_type == MIDI_CHAN_AT) ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/midi_byte_classify.sv
// Combinational classification of a single MIDI byte; shared with the
// MIDI-thru path.
module midi_byte_classify
  import midi_pkg::*;
(
  input  logic [7:0] data_byte,
  output logic       is_status,
  output logic       is_realtime,
  output logic       is_system,
  output logic [1:0] nbytes
);

  // nbytes is only meaningful for channel-voice status bytes; 0 otherwise.
  always_comb begin
    is_status   = data_byte[7];
    is_realtime = (data_byte >= MIDI_RT_MIN);
    is_system   = (data_byte >= MIDI_SYS_MIN) && !is_realtime;
    nbytes      = 2'd0;
    if (is_status && (data_byte < MIDI_SYS_MIN))
      nbytes = midi_nbytes(midi_type_t'(data_byte[6:4]));
  end

endmodule

// File: rtl/midi_rx_sequencer.sv
// Pops bytes from the UART receive buffer and parses them into complete
// channel-voice messages, presented over a valid/ready handshake.
module midi_rx_sequencer
  import midi_pkg::*;
#(
  parameter bit         OMNI           = 1'b1,
  parameter logic [3:0] LISTEN_CHANNEL = 4'd0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       uart_valid,
  input  logic [7:0] uart_data,
  output logic       uart_re,
  output logic       msg_valid,
  input  logic       msg_ready,
  output logic [2:0] msg_type,
  output logic [3:0] msg_channel,
  output logic [6:0] msg_data1,
  output logic [6:0] msg_data2
);

  rx_state_t  state, state_nxt;
  logic [7:0] byte_q;
  logic [7:0] rs;
  logic       rs_valid;
  logic       rs_two;
  logic       idx;
  logic [6:0] d1;

  logic       cls_status, cls_realtime, cls_system;
  logic [1:0] cls_nbytes;

  logic       complete, accept;
  logic [2:0] out_type;
  logic [6:0] out_d1, out_d2;

  midi_byte_classify u_classify (
    .data_byte   (byte_q),
    .is_status   (cls_status),
    .is_realtime (cls_realtime),
    .is_system   (cls_system),
    .nbytes      (cls_nbytes)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_WAIT;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_WAIT:  if (uart_valid) state_nxt = ST_POP;
      ST_POP:   state_nxt = ST_PARSE;
      ST_PARSE: state_nxt = accept ? ST_EMIT : ST_WAIT;
      ST_EMIT:  if (msg_ready) state_nxt = ST_WAIT;
      default:  state_nxt = ST_WAIT;
    endcase
  end

  always_comb begin
    uart_re   = (state == ST_POP);
    msg_valid = (state == ST_EMIT);
  end

  // Message completion for the byte held in byte_q, evaluated against the
  // current running status; only acted upon in PARSE.
  always_comb begin
    complete = 1'b0;
    out_d1   = d1;
    out_d2   = 7'd0;
    if (!cls_status && rs_valid) begin
      if (!rs_two) begin
        complete = 1'b1;
        out_d1   = byte_q[6:0];
      end else if (idx) begin
        complete = 1'b1;
        out_d2   = byte_q[6:0];
      end
    end
    out_type = rs[6:4];
    if (rs[6:4] == MIDI_NOTE_ON && out_d2 == 7'd0)
      out_type = MIDI_NOTE_OFF;
    accept = complete && (OMNI || rs[3:0] == LISTEN_CHANNEL);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      byte_q   <= 8'd0;
      rs       <= 8'd0;
      rs_valid <= 1'b0;
      rs_two   <= 1'b0;
      idx      <= 1'b0;
      d1       <= 7'd0;
    end else begin
      if (state == ST_WAIT && uart_valid)
        byte_q <= uart_data;
      if (state == ST_PARSE) begin
        if (cls_realtime) begin
          rs_valid <= rs_valid;
        end else if (cls_system) begin
          rs_valid <= 1'b0;
          idx      <= 1'b0;
        end else if (cls_status) begin
          rs       <= byte_q;
          rs_valid <= 1'b1;
          rs_two   <= (cls_nbytes == 2'd2);
          idx      <= 1'b0;
        end else if (rs_valid && rs_two) begin
          if (!idx) begin
            d1  <= byte_q[6:0];
            idx <= 1'b1;
          end else begin
            idx <= 1'b0;
          end
        end
      end
    end
  end

  // Fields only change in PARSE, so they stay put for the whole of EMIT.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      msg_type    <= 3'd0;
      msg_channel <= 4'd0;
      msg_data1   <= 7'd0;
      msg_data2   <= 7'd0;
    end else if (state == ST_PARSE && accept) begin
      msg_type    <= out_type;
      msg_channel <= rs[3:0];
      msg_data1   <= out_d1;
      msg_data2   <= out_d2;
    end
  end

endmodule

// File: tb/tb_midi_rx_sequencer.sv
// Self-checking bench for midi_rx_sequencer: directed scenarios plus random
// byte streams checked against a queue-based MIDI parser model.
module tb_midi_rx_sequencer;

  typedef struct packed {
    logic [2:0] t;
    logic [3:0] ch;
    logic [6:0] d1;
    logic [6:0] d2;
  } msg_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic       va = 1'b0, vb = 1'b0;
  logic [7:0] da = 8'h00, db = 8'h00;
  logic       re_a, re_b, mv_a, mv_b;
  logic       rdy_a = 1'b0, rdy_b = 1'b0;
  logic [2:0] ta, tb;
  logic [3:0] cha, chb;
  logic [6:0] d1a, d2a, d1b, d2b;

  int errors = 0;
  int checks = 0;
  msg_t got_a[$];
  msg_t got_b[$];
  msg_t exp_q[$];

  always #5 clk = ~clk;

  midi_rx_sequencer dut_a (
    .clk(clk), .resetn(resetn), .uart_valid(va), .uart_data(da), .uart_re(re_a),
    .msg_valid(mv_a), .msg_ready(rdy_a), .msg_type(ta), .msg_channel(cha),
    .msg_data1(d1a), .msg_data2(d2a)
  );

  midi_rx_sequencer #(.OMNI(1'b0), .LISTEN_CHANNEL(4'd2)) dut_b (
    .clk(clk), .resetn(resetn), .uart_valid(vb), .uart_data(db), .uart_re(re_b),
    .msg_valid(mv_b), .msg_ready(rdy_b), .msg_type(tb), .msg_channel(chb),
    .msg_data1(d1b), .msg_data2(d2b)
  );

  // UART receive buffer models: a read strobe pops at the edge, and the
  // visible head/valid update just after it.
  always @(posedge clk) begin
    logic [7:0] tmp;
    if (re_a && qa.size() > 0) tmp = qa.pop_front();
    if (re_b && qb.size() > 0) tmp = qb.pop_front();
    #1;
    va = (qa.size() > 0);
    da = va ? qa[0] : 8'h00;
    vb = (qb.size() > 0);
    db = vb ? qb[0] : 8'h00;
  end

  always @(posedge clk) begin
    if (mv_a && rdy_a) got_a.push_back({ta, cha, d1a, d2a});
    if (mv_b && rdy_b) got_b.push_back({tb, chb, d1b, d2b});
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Parser model: tracks running status and pending data bytes directly.
  function automatic void model(input logic [7:0] s[$], input bit omni, input logic [3:0] lch);
    int status;
    int data[$];
    status = -1;
    exp_q.delete();
    foreach (s[i]) begin
      int b;
      int need;
      msg_t m;
      b = int'(s[i]);
      if (b >= 'hF8) continue;
      if (b >= 'hF0) begin status = -1; data.delete(); continue; end
      if (b >= 'h80) begin status = b; data.delete(); continue; end
      if (status < 0) continue;
      data.push_back(b);
      need = (((status >> 4) & 7) == 4 || ((status >> 4) & 7) == 5) ? 1 : 2;
      if (data.size() == need) begin
        m.t  = 3'((status >> 4) & 7);
        m.ch = 4'(status & 15);
        m.d1 = 7'(data[0]);
        m.d2 = (need == 2) ? 7'(data[1]) : 7'd0;
        if (m.t == 3'd1 && m.d2 == 7'd0) m.t = 3'd0;
        if (omni || m.ch == lch) exp_q.push_back(m);
        data.delete();
      end
    end
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    rdy_a = 1'b0;
    rdy_b = 1'b0;
    qa.delete();
    qb.delete();
    repeat (3) tick();
    resetn = 1'b1;
    repeat (2) tick();
    got_a.delete();
    got_b.delete();
  endtask

  task automatic apply_stimulus(input bit to_b, input logic [7:0] seq[$]);
    foreach (seq[i]) begin
      if (to_b) qb.push_back(seq[i]);
      else qa.push_back(seq[i]);
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((qa.size() > 0 || va || qb.size() > 0 || vb) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("[TB] FAIL %s_drain: queues a=%0d b=%0d still pending, required empty within %0d cycles",
               name, qa.size(), qb.size(), budget);
    end
    repeat (8) tick();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) tick();
    checks++;
    if ({re_a, mv_a, ta, cha, d1a, d2a} !== 23'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got re=%b valid=%b fields=%h/%h/%h/%h, required all 0",
               re_a, mv_a, ta, cha, d1a, d2a);
    end
    checks++;
    if ({re_b, mv_b} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_outputs_b: got re=%b valid=%b, required 0 0", re_b, mv_b);
    end
    do_reset();
    checks++;
    if (re_a !== 1'b0 || mv_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got re=%b valid=%b, required 0 0", re_a, mv_a);
    end
  endtask

  task automatic test_basic_latency();
    logic [7:0] s[$];
    int n;
    msg_t got;
    do_reset();
    rdy_a = 1'b1;
    s = '{8'h90, 8'h3C};
    apply_stimulus(0, s);
    drain("basic", 40);
    s = '{8'h64};
    apply_stimulus(0, s);
    n = 0;
    while (!va && n < 5) begin tick(); n++; end
    checks++;
    if (!va) begin
      errors++;
      $display("[TB] FAIL basic_uart_valid: got 0, required 1");
    end
    tick();
    checks++;
    if (re_a !== 1'b1 || mv_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL latency_re_t1: got re=%b valid=%b, required re=1 valid=0", re_a, mv_a);
    end
    tick();
    checks++;
    if (re_a !== 1'b0 || mv_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL latency_t2: got re=%b valid=%b, required re=0 valid=0", re_a, mv_a);
    end
    tick();
    checks++;
    if (mv_a !== 1'b1) begin
      errors++;
      $display("[TB] FAIL latency_valid_t3: got %b, required 1", mv_a);
    end
    got = {ta, cha, d1a, d2a};
    checks++;
    if (got !== {3'd1, 4'd0, 7'h3C, 7'h64}) begin
      errors++;
      $display("[TB] FAIL basic_fields: got type=%0d ch=%0d d1=%h d2=%h, required 1 0 3c 64",
               ta, cha, d1a, d2a);
    end
    repeat (4) tick();
    checks++;
    if (got_a.size() != 1) begin
      errors++;
      $display("[TB] FAIL basic_count: got %0d messages, required 1", got_a.size());
    end
  endtask

  task automatic test_directed(input string name, input logic [7:0] s[$], input msg_t exp[$]);
    do_reset();
    rdy_a = 1'b1;
    apply_stimulus(0, s);
    drain(name, 100);
    checks++;
    if (got_a.size() != exp.size()) begin
      errors++;
      $display("[TB] FAIL %s_count: got %0d messages, required %0d", name, got_a.size(), exp.size());
    end
    foreach (exp[i]) begin
      msg_t g;
      g = (i < got_a.size()) ? got_a[i] : '1;
      checks++;
      if (g !== exp[i]) begin
        errors++;
        $display("[TB] FAIL %s_msg%0d: got type=%0d ch=%0d d1=%h d2=%h, required type=%0d ch=%0d d1=%h d2=%h",
                 name, i, g.t, g.ch, g.d1, g.d2, exp[i].t, exp[i].ch, exp[i].d1, exp[i].d2);
      end
    end
  endtask

  task automatic test_running_status();
    logic [7:0] s[$];
    msg_t e[$];
    s = '{8'h91, 8'h40, 8'h50, 8'h41, 8'h00};
    e = '{{3'd1, 4'd1, 7'h40, 7'h50}, {3'd0, 4'd1, 7'h41, 7'h00}};
    test_directed("running_status", s, e);
  endtask

  task automatic test_realtime_cc_program();
    logic [7:0] s[$];
    msg_t e[$];
    s = '{8'hB0, 8'h07, 8'hF8, 8'h7F, 8'hC5, 8'h0A};
    e = '{{3'd3, 4'd0, 7'h07, 7'h7F}, {3'd4, 4'd5, 7'h0A, 7'h00}};
    test_directed("realtime_cc", s, e);
  endtask

  task automatic test_sysex();
    logic [7:0] s[$];
    msg_t e[$];
    s = '{8'hF0, 8'h01, 8'h02, 8'hF7, 8'h10, 8'h80, 8'h30, 8'h00};
    e = '{{3'd0, 4'd0, 7'h30, 7'h00}};
    test_directed("sysex", s, e);
  endtask

  task automatic test_filter_stall();
    logic [7:0] s[$];
    int n;
    int bad;
    msg_t held;
    do_reset();
    s = '{8'h93, 8'h10, 8'h20, 8'h92, 8'h10, 8'h20};
    apply_stimulus(1, s);
    n = 0;
    while (!mv_b && n < 80) begin tick(); n++; end
    held = {3'd1, 4'd2, 7'h10, 7'h20};
    checks++;
    if (!mv_b || {tb, chb, d1b, d2b} !== held) begin
      errors++;
      $display("[TB] FAIL filter_fields: got valid=%b type=%0d ch=%0d d1=%h d2=%h, required 1 1 2 10 20",
               mv_b, tb, chb, d1b, d2b);
    end
    s = '{8'h55};
    apply_stimulus(1, s);
    bad = 0;
    repeat (50) begin
      tick();
      if (re_b !== 1'b0 || mv_b !== 1'b1 || {tb, chb, d1b, d2b} !== held) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL stall_hold: got %0d disturbed cycles, required 0", bad);
    end
    rdy_b = 1'b1;
    tick();
    checks++;
    if (mv_b !== 1'b0 || re_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL accept_c1: got valid=%b re=%b, required 0 0", mv_b, re_b);
    end
    tick();
    checks++;
    if (re_b !== 1'b1) begin
      errors++;
      $display("[TB] FAIL accept_c2_re: got %b, required 1", re_b);
    end
    drain("filter", 40);
    checks++;
    if (got_b.size() != 1) begin
      errors++;
      $display("[TB] FAIL filter_count: got %0d messages, required 1", got_b.size());
    end
  endtask

  task automatic test_reset_mid_message();
    logic [7:0] s[$];
    int n;
    do_reset();
    rdy_a = 1'b1;
    s = '{8'h90};
    apply_stimulus(0, s);
    drain("midreset_a", 40);
    resetn = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    s = '{8'h3C, 8'h64};
    apply_stimulus(0, s);
    drain("midreset_b", 40);
    checks++;
    if (got_a.size() != 0) begin
      errors++;
      $display("[TB] FAIL reset_mid_message: got %0d messages, required 0", got_a.size());
    end
    rdy_a = 1'b0;
    s = '{8'h90, 8'h3C, 8'h64};
    apply_stimulus(0, s);
    n = 0;
    while (!mv_a && n < 40) begin tick(); n++; end
    checks++;
    if (mv_a !== 1'b1) begin
      errors++;
      $display("[TB] FAIL recover_after_reset: got valid=%b, required 1", mv_a);
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({mv_a, ta, cha, d1a, d2a} !== 22'd0) begin
      errors++;
      $display("[TB] FAIL async_reset_emit: got valid=%b fields=%h/%h/%h/%h, required all 0",
               mv_a, ta, cha, d1a, d2a);
    end
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_random();
    for (int iter = 0; iter < 4; iter++) begin
      logic [7:0] s[$];
      msg_t exp_a[$];
      msg_t exp_b[$];
      int n;
      do_reset();
      s.push_back(8'h90 | 8'($urandom_range(2, 3)));
      for (int k = 0; k < 60; k++) begin
        int r;
        r = $urandom_range(0, 19);
        if (r < 3)       s.push_back(8'($urandom_range(8, 14) << 4) | 8'($urandom_range(2, 3)));
        else if (r < 5)  s.push_back(8'($urandom_range(8'hF8, 8'hFF)));
        else if (r < 6)  s.push_back(8'($urandom_range(8'hF0, 8'hF7)));
        else if (r < 7)  s.push_back(8'h00);
        else             s.push_back(8'($urandom_range(0, 127)));
      end
      model(s, 1'b1, 4'd0);
      exp_a = exp_q;
      model(s, 1'b0, 4'd2);
      exp_b = exp_q;
      apply_stimulus(0, s);
      apply_stimulus(1, s);
      n = 0;
      while ((qa.size() > 0 || va || qb.size() > 0 || vb) && n < 3000) begin
        rdy_a = 1'($urandom_range(0, 1));
        rdy_b = 1'($urandom_range(0, 1));
        tick();
        n++;
      end
      rdy_a = 1'b1;
      rdy_b = 1'b1;
      drain("random", 20);
      checks++;
      if (got_a.size() != exp_a.size() || got_b.size() != exp_b.size()) begin
        errors++;
        $display("[TB] FAIL random%0d_count: got a=%0d b=%0d, required a=%0d b=%0d",
                 iter, got_a.size(), got_b.size(), exp_a.size(), exp_b.size());
      end
      foreach (exp_a[i]) begin
        msg_t g;
        g = (i < got_a.size()) ? got_a[i] : '1;
        checks++;
        if (g !== exp_a[i]) begin
          errors++;
          $display("[TB] FAIL random%0d_a_msg%0d: got %h, required %h", iter, i, g, exp_a[i]);
        end
      end
      foreach (exp_b[i]) begin
        msg_t g;
        g = (i < got_b.size()) ? got_b[i] : '1;
        checks++;
        if (g !== exp_b[i]) begin
          errors++;
          $display("[TB] FAIL random%0d_b_msg%0d: got %h, required %h", iter, i, g, exp_b[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_running_status();
    test_realtime_cc_program();
    test_sysex();
    test_filter_stall();
    test_reset_mid_message();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
